// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
//   UART-style 8N1 receiver. RX is brought into the CLK domain through a
//   two-flop synchronizer. A small FSM centres its samples in each bit cell.
//   Each correctly framed byte is presented on DATA together with the READY
//   level. READY stays high until the next valid start bit.
//
// Ports
//   CLK        system clock, rising edge
//   RESET      asynchronous, active-high reset
//   RX         serial line (idles high), asynchronous to CLK
//   DATA[7:0]  last correctly framed byte
//   READY      DATA holds a new byte (level, cleared by the next valid start)
//   FRAME_ERR  last frame ended with a low stop bit
//   BUSY       frame reception in progress (FSM not idle)
// -----------------------------------------------------------------------------
module serial_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       READY,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int             HALF   = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_LINE
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic             rx_sync_p0;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;

  logic smp;
  logic start_ok;
  logic data_smp;
  logic stop_ok;
  logic stop_bad;

  // Synchronizer stage: both flops come out of reset as an idle (high) line
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= RX;
      rx_s       <= rx_sync_p0;
    end
  end

  // Next-state and sample strobes
  always_comb begin
    state_nxt = state_q;
    smp       = 1'b0;
    start_ok  = 1'b0;
    data_smp  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          smp = 1'b1;
          if (!rx_s) begin
            start_ok  = 1'b1;
            state_nxt = ST_DATA;
          end else begin
            // Line went back high before mid start bit: a glitch
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          smp      = 1'b1;
          data_smp = 1'b1;
          if (bit_idx_q == 3'd7) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_M1) begin
          smp = 1'b1;
          if (rx_s) begin
            stop_ok   = 1'b1;
            // Back to IDLE half a bit early, so a start bit that follows
            // the stop bit with no gap is still caught
            state_nxt = ST_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = ST_WAIT_LINE;
          end
        end
      end
      ST_WAIT_LINE: begin
        // A held-low (break) line must not look like a start bit
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, timing counter, shift register and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      DATA      <= 8'h00;
      READY     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if (smp || (state_nxt != state_q) ||
          (state_q == ST_IDLE) || (state_q == ST_WAIT_LINE))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;

      if (start_ok)
        bit_idx_q <= 3'd0;
      else if (data_smp)
        bit_idx_q <= bit_idx_q + 3'd1;

      if (data_smp)
        shreg_q[bit_idx_q] <= rx_s;

      if (start_ok) begin
        READY     <= 1'b0;
        FRAME_ERR <= 1'b0;
      end else if (stop_ok) begin
        DATA  <= shreg_q;
        READY <= 1'b1;
      end else if (stop_bad) begin
        FRAME_ERR <= 1'b1;
      end
    end
  end

  assign BUSY = (state_q != ST_IDLE);

endmodule
